// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path constants for the instruction fetch queue.
// Parameter defaults of the fetch stage and its FIFO refer to these.
package inst_fetch_queue_pkg;

    localparam int INST_LENGTH        = 32;
    localparam int INSTMEM_ADDR_WIDTH = 8;
    localparam int FETCHQ_DEPTH       = 4;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Show-ahead FIFO holding {instruction, pc} entries for the fetch queue.
// Flush clears pointers and count; the head is visible without a pop.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int WIDTH = INST_LENGTH + INSTMEM_ADDR_WIDTH,
    parameter int DEPTH = FETCHQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable while count is nonzero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= din;
    end

    assign dout = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetching fetch stage: owns the fetch PC, buffers returned
// instructions with their PC, and hands them to decode on valid/ready.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int INST_W = INST_LENGTH,
    parameter int ADDR_W = INSTMEM_ADDR_WIDTH,
    parameter int DEPTH  = FETCHQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [INST_W-1:0]      imem_inst,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_W-1:0]      out_inst,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CRW = CW + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        req_pc_q;
    logic                     req_q;
    logic [CW-1:0]            count;
    logic [CRW-1:0]           credit;
    logic [INST_W+ADDR_W-1:0] head;
    logic                     issue;
    logic                     push;
    logic                     pop;

    // The in-flight request reserves a slot so a response always fits.
    assign credit    = {1'b0, count} + {{CW{1'b0}}, req_q};
    assign issue     = fetch_en & ~redirect_valid
                     & (credit < CRW'(DEPTH));
    assign push      = req_q & ~redirect_valid;
    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;

    assign imem_addr = fetch_pc;
    assign occupancy = count;
    assign {out_inst, out_pc} = head;

    fetch_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_inst, req_pc_q}),
        .dout  (head),
        .count (count)
    );

    // Fetch PC and outstanding-request tracking; redirect drops the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            req_q    <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                req_pc_q <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic,
// with delivered instructions checked against an expected PC stream.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;
    int n_fire = 0;
    int f0;

    // Expected program-order stream: consecutive PCs from the last restart.
    logic [7:0] sb[$];
    logic [7:0] gen_pc = '0;
    logic [7:0] mon_e;

    inst_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [7:0] a);
        return 32'h100 + {24'd0, a};
    endfunction

    // Instruction memory: data for the sampled address one cycle later.
    always @(posedge clk) imem_inst <= inst_of(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic topup();
        while (sb.size() < 16) begin
            sb.push_back(gen_pc);
            gen_pc = gen_pc + 8'd1;
        end
    endtask

    task automatic cyc(input logic fe, input logic rv,
                       input logic [7:0] ra, input logic rdy);
        @(negedge clk);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_addr  = ra;
        out_ready      = rdy;
        if (rv) begin
            sb.delete();
            gen_pc = ra;
        end
        topup();
    endtask

    task automatic start(input logic rdy);
        @(negedge clk);
        reset          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        sb.delete();
        gen_pc = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        fetch_en  = 1'b1;
        out_ready = rdy;
        topup();
    endtask

    // Monitor: every accepted head must be the next expected PC/instruction.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("occ_bound", 32'(occupancy <= 3'd4), 1);
            if (redirect_valid) begin
                chk("no_fire_on_redirect", 32'(out_valid), 0);
            end else if (out_valid && out_ready) begin
                n_fire++;
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_pc", 32'(out_pc), 32'(mon_e));
                    chk("out_inst", out_inst, inst_of(mon_e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2 reset = 1'b0;
        #2;
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", 32'(out_pc), 0);
        chk("rst_occ", 32'(occupancy), 0);

        // Cold start: first head after the second edge.
        start(1'b1);
        cyc(1, 0, 0, 1);
        #2;
        chk("e1_valid", 32'(out_valid), 0);
        chk("e1_addr", 32'(imem_addr), 1);
        cyc(1, 0, 0, 1);
        #2;
        chk("e2_valid", 32'(out_valid), 1);
        chk("e2_pc", 32'(out_pc), 0);
        chk("e2_inst", out_inst, 32'h100);
        #2;
        f0 = n_fire;
        repeat (8) cyc(1, 0, 0, 1);
        #4;
        chk("stream_rate", 32'(n_fire - f0), 8);

        // Backpressure: fetch stops once four slots are committed.
        start(1'b0);
        repeat (10) cyc(1, 0, 0, 0);
        #2;
        chk("bp_addr", 32'(imem_addr), 4);
        chk("bp_occ", 32'(occupancy), 4);
        chk("bp_head", 32'(out_pc), 0);
        f0 = n_fire;
        repeat (12) cyc(1, 0, 0, 1);
        #4;
        chk("bp_drain_rate", 32'((n_fire - f0) >= 11), 1);

        // Redirect while streaming at PC 5.
        start(1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 1);
            #2;
            if (out_valid && out_pc == 8'd5) break;
        end
        chk("rd_at_pc5", 32'(out_pc), 5);
        cyc(1, 1, 8'h40, 1);
        #2;
        chk("rd_r_valid", 32'(out_valid), 0);
        cyc(1, 0, 0, 1);
        #2;
        chk("rd_r1_valid", 32'(out_valid), 0);
        cyc(1, 0, 0, 1);
        #2;
        chk("rd_r2_valid", 32'(out_valid), 0);
        cyc(1, 0, 0, 1);
        #2;
        chk("rd_tgt_valid", 32'(out_valid), 1);
        chk("rd_tgt_pc", 32'(out_pc), 32'h40);
        repeat (2) cyc(1, 0, 0, 1);

        // PC wrap-around.
        cyc(1, 1, 8'hFE, 1);
        f0 = n_fire;
        repeat (7) cyc(1, 0, 0, 1);
        #4;
        chk("wrap_fires", 32'((n_fire - f0) >= 4), 1);

        // Full queue: one pop, refill, no loss or duplication.
        start(1'b0);
        repeat (10) cyc(1, 0, 0, 0);
        #2;
        chk("full_occ", 32'(occupancy), 4);
        cyc(1, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0);
        #2;
        chk("refill_occ", 32'(occupancy), 4);
        chk("refill_addr", 32'(imem_addr), 5);
        repeat (10) cyc(1, 0, 0, 1);

        // Asynchronous reset with three entries buffered.
        start(1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            #2;
            if (occupancy == 3'd3) break;
        end
        chk("mr_occ3", 32'(occupancy), 3);
        reset = 1'b0;
        sb.delete();
        gen_pc = '0;
        #1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_occ", 32'(occupancy), 0);
        chk("mr_addr", 32'(imem_addr), 0);
        chk("mr_pc", 32'(out_pc), 0);
        chk("mr_inst", out_inst, 0);
        start(1'b1);
        cyc(1, 0, 0, 1);
        #2;
        chk("mr_e1_valid", 32'(out_valid), 0);
        cyc(1, 0, 0, 1);
        #2;
        chk("mr_e2_valid", 32'(out_valid), 1);
        chk("mr_e2_pc", 32'(out_pc), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) < 8),
                1'($urandom_range(0, 19) == 0),
                8'($urandom),
                1'($urandom_range(0, 9) < 6));
        end

        // Forward progress once fetch and consumer are both enabled.
        #4;
        f0 = n_fire;
        repeat (12) cyc(1, 0, 0, 1);
        #4;
        chk("liveness", 32'((n_fire - f0) >= 9), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
